// File: rtl/aes_inv_key_sched_128.sv
// AES-128 inverse key schedule: runs the forward schedule to rk10, then streams rk10..rk0.
// Optional macro AES_INV_KS_DIRECT_LOAD_EN adds key_is_last to load rk10 directly.
module aes_inv_ks_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] b;

  // Inverse followed by the AES affine transform
  always_comb begin
    b = ginv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
          ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes_inv_key_sched_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
`ifdef AES_INV_KS_DIRECT_LOAD_EN
  input  logic         key_is_last,
`endif
  input  logic         clr,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    REV
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        direct;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sb_in, sb_out, t;
  logic [3:0]  rc_sel;
  logic [7:0]  rc;
  logic [127:0] fwd_key, inv_key;

`ifdef AES_INV_KS_DIRECT_LOAD_EN
  assign direct = key_is_last;
`else
  assign direct = 1'b0;
`endif

  assign w0 = rk_data[127:96];
  assign w1 = rk_data[95:64];
  assign w2 = rk_data[63:32];
  assign w3 = rk_data[31:0];

  // In REV the old w3 is recovered first, since the inverse needs its S-box image
  assign sb_in = (state == REV) ? {w3[23:0] ^ w2[23:0], w3[31:24] ^ w2[31:24]}
                                : {w3[23:0], w3[31:24]};

  aes_inv_ks_sbox u_sb0 (.a(sb_in[31:24]), .s(sb_out[31:24]));
  aes_inv_ks_sbox u_sb1 (.a(sb_in[23:16]), .s(sb_out[23:16]));
  aes_inv_ks_sbox u_sb2 (.a(sb_in[15:8]),  .s(sb_out[15:8]));
  aes_inv_ks_sbox u_sb3 (.a(sb_in[7:0]),   .s(sb_out[7:0]));

  assign rc_sel = (state == REV) ? rk_idx : cnt;

  // Round constant for rounds 1..10
  always_comb begin
    case (rc_sel)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign t = sb_out ^ {rc, 24'h000000};

  // Forward and inverse round-key steps share the same S-box result
  always_comb begin
    fwd_key[127:96] = w0 ^ t;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    inv_key[127:96] = w0 ^ t;
    inv_key[95:64]  = w1 ^ w0;
    inv_key[63:32]  = w2 ^ w1;
    inv_key[31:0]   = w3 ^ w2;
  end

  assign rk_last = rk_valid && (rk_idx == 4'd0);

  // Control FSM with the key register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= 4'd0;
      rk_data  <= '0;
      cnt      <= 4'd0;
    end else if (clr) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= 4'd0;
      cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rk_data <= key_in;
            busy    <= 1'b1;
            if (direct) begin
              state    <= REV;
              rk_idx   <= 4'd10;
              rk_valid <= 1'b1;
              cnt      <= 4'd0;
            end else begin
              state <= FWD;
              cnt   <= 4'd1;
            end
          end
        end
        FWD: begin
          rk_data <= fwd_key;
          if (cnt == 4'd10) begin
            state    <= REV;
            rk_idx   <= 4'd10;
            rk_valid <= 1'b1;
            cnt      <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        REV: begin
          if (rk_ready) begin
            if (rk_idx == 4'd0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
            end else begin
              rk_data <= inv_key;
              rk_idx  <= rk_idx - 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched_128.sv
// Directed bench for aes_inv_key_sched_128 using the FIPS-197 A.1 key expansion.
// Define AES_INV_KS_DIRECT_LOAD_EN to include the direct-load scenario.
module tb_aes_inv_key_sched_128;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
`ifdef AES_INV_KS_DIRECT_LOAD_EN
  logic         key_is_last = 1'b0;
`endif
  logic         clr = 1'b0;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  logic [127:0] rk_tab [0:10];

  aes_inv_key_sched_128 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key_in(key_in),
`ifdef AES_INV_KS_DIRECT_LOAD_EN
    .key_is_last(key_is_last),
`endif
    .clr(clr),
    .busy(busy),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_data(rk_data),
    .rk_idx(rk_idx),
    .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0)
      begin errors++; $display("FAIL reset_flags busy=%b valid=%b last=%b want 0 0 0", busy, rk_valid, rk_last); end
    checks++;
    if (rk_idx !== 4'd0 || rk_data !== 128'd0)
      begin errors++; $display("FAIL reset_data idx=%0d data=%h want 0 0", rk_idx, rk_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1)
      begin errors++; $display("FAIL fips_busy got=%b want=1", busy); end
    repeat (9) @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0)
      begin errors++; $display("FAIL fips_early_valid got=%b want=0", rk_valid); end
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b1 || rk_data !== rk_tab[10] || rk_idx !== 4'd10)
      begin errors++; $display("FAIL fips_rk10 valid=%b data=%h idx=%0d want 1 %h 10", rk_valid, rk_data, rk_idx, rk_tab[10]); end
    for (int r = 9; r >= 0; r--) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b1 || rk_data !== rk_tab[r] || rk_idx !== 4'(r) || rk_last !== (r == 0))
        begin errors++; $display("FAIL fips_beat valid=%b data=%h idx=%0d last=%b want 1 %h %0d %b", rk_valid, rk_data, rk_idx, rk_last, rk_tab[r], r, (r == 0)); end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0)
      begin errors++; $display("FAIL fips_done busy=%b valid=%b last=%b want 0 0 0", busy, rk_valid, rk_last); end
  endtask

  task automatic test_backpressure();
    int xfers;
    bit stalled;
    bit done;
    logic [127:0] d;
    logic [3:0] x;
    xfers = 0;
    stalled = 1'b0;
    done = 1'b0;
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (rk_valid) begin
        checks++;
        if (rk_data !== rk_tab[rk_idx])
          begin errors++; $display("FAIL bp_beat idx=%0d data=%h want %h", rk_idx, rk_data, rk_tab[rk_idx]); end
        if (rk_idx == 4'd7 && !stalled) begin
          stalled = 1'b1;
          rk_ready = 1'b0;
          d = rk_data;
          x = rk_idx;
          repeat (5) begin
            @(negedge clk);
            checks++;
            if (rk_data !== d || rk_idx !== x || rk_valid !== 1'b1)
              begin errors++; $display("FAIL bp_hold data=%h idx=%0d valid=%b want %h %0d 1", rk_data, rk_idx, rk_valid, d, x); end
          end
          rk_ready = 1'b1;
        end
        xfers++;
        if (rk_idx == 4'd0) done = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (!done || !stalled)
      begin errors++; $display("FAIL bp_timeout done=%b stalled=%b want 1 1", done, stalled); end
    checks++;
    if (xfers != 11 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_count xfers=%0d busy=%b want 11 0", xfers, busy); end
  endtask

  task automatic test_start_ignored();
    int n;
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    key_in = ALT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_in = KEY;
    n = 0;
    while (!rk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 7)
      begin errors++; $display("FAIL ign_latency waited=%0d want 7", n); end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_data !== rk_tab[r] || rk_idx !== 4'(r))
        begin errors++; $display("FAIL ign_beat valid=%b data=%h idx=%0d want 1 %h %0d", rk_valid, rk_data, rk_idx, rk_tab[r], r); end
      if (r == 8) begin
        key_in = ALT;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      key_in = KEY;
    end
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL ign_done busy=%b valid=%b want 0 0", busy, rk_valid); end
  endtask

  task automatic test_clr();
    int n;
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!rk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10)
      begin errors++; $display("FAIL clr_latency waited=%0d want 10", n); end
    repeat (6) @(negedge clk);
    checks++;
    if (rk_idx !== 4'd4 || rk_data !== rk_tab[4])
      begin errors++; $display("FAIL clr_at4 idx=%0d data=%h want 4 %h", rk_idx, rk_data, rk_tab[4]); end
    clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_last !== 1'b0)
      begin errors++; $display("FAIL clr_idle valid=%b busy=%b last=%b want 0 0 0", rk_valid, busy, rk_last); end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 || rk_idx !== 4'd0 || rk_data !== 128'd0)
      begin errors++; $display("FAIL arst_mid busy=%b valid=%b last=%b idx=%0d data=%h want all 0", busy, rk_valid, rk_last, rk_idx, rk_data); end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1)
      begin errors++; $display("FAIL arst_first_start busy=%b want 1", busy); end
    n = 0;
    while (!rk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10 || rk_data !== rk_tab[10] || rk_idx !== 4'd10)
      begin errors++; $display("FAIL arst_rerun waited=%0d data=%h idx=%0d want 10 %h 10", n, rk_data, rk_idx, rk_tab[10]); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

`ifdef AES_INV_KS_DIRECT_LOAD_EN
  task automatic test_direct_load();
    @(negedge clk);
    rk_ready = 1'b1;
    key_in = rk_tab[10];
    key_is_last = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_is_last = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_data !== rk_tab[r] || rk_idx !== 4'(r))
        begin errors++; $display("FAIL direct_beat valid=%b data=%h idx=%0d want 1 %h %0d", rk_valid, rk_data, rk_idx, rk_tab[r], r); end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL direct_done busy=%b valid=%b want 0 0", busy, rk_valid); end
  endtask
`endif

  initial begin
    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_clr();
    test_async_reset();
`ifdef AES_INV_KS_DIRECT_LOAD_EN
    test_direct_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched_128.md
AES_INV_KEY_SCHED_128 -- requirements
Module: aes_inv_key_sched_128

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset: clk (rising edge) and rst; no other clock or reset.
REQ-002 The port list SHALL be as follows, one port per line:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  start  in  1  load request, sampled only in IDLE
  key_in  in  128  cipher key rk0, big-endian words w0=[127:96]..w3=[31:0]
  clr  in  1  synchronous abort to IDLE
  busy  out  1  high in every state except IDLE
  rk_valid  out  1  rk_data holds a valid round key
  rk_ready  in  1  consumer accepts the round key
  rk_data  out  128  current round key
  rk_idx  out  4  round number of rk_data, 10 down to 0
  rk_last  out  1  rk_valid and rk_idx==0

Function
REQ-003 The block SHALL have three states: IDLE, FWD and REV.
REQ-004 In IDLE with start=1 (the acceptance edge E), the block SHALL load key_in into the key register, set the step counter to 1 and enter FWD.
REQ-005 In FWD, each edge SHALL apply the AES-128 forward step to the key register using rcon(cnt) and then increment cnt, using Rcon 01,02,04,08,10,20,40,80,1B,36 for cnt=1..10.
REQ-006 After the FWD edge with cnt=10, the block SHALL enter REV with rk_idx=10, so rk_valid rises after edge E+10 holding rk10.
REQ-007 In REV, rk_valid SHALL be 1 and rk_data/rk_idx SHALL remain stable until a transfer (rk_valid and rk_ready).
REQ-008 On a transfer with rk_idx=r>0, the key register SHALL be updated in the same edge to rk[r-1] by the inverse step below, rk_idx SHALL become r-1, and rk_valid SHALL stay 1, giving one key per cycle under a continuous rk_ready.
  - w3=w3'^w2'
  - w2=w2'^w1'
  - w1=w1'^w0'
  - w0=w0'^SubWord(RotWord(w3))^{rcon(r),24'h0}
REQ-009 On a transfer with rk_idx=0, the block SHALL return to IDLE, and rk_valid SHALL be 0 after that edge.
REQ-010 The four S-box instances SHALL be shared between the forward and inverse step through a 32-bit input mux.
REQ-011 start SHALL be ignored when the block is not in IDLE.
REQ-012 clr SHALL force IDLE on the next edge from any state, take priority over start and over a transfer, and leave rk_data unspecified.
REQ-013 While the block is not in REV, rk_valid and rk_last SHALL be 0 and rk_ready SHALL be ignored.

Reset
REQ-014 Asserting rst SHALL force, asynchronously and in any state including mid-FWD or mid-REV, state=IDLE, busy=0, rk_valid=0, rk_last=0, rk_idx=0, rk_data=0 and cnt=0.
REQ-015 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-016 When the macro AES_INV_KS_DIRECT_LOAD_EN is defined, the block SHALL have an extra input key_is_last (1 bit), and a start with key_is_last=1 SHALL load key_in as rk10 and go directly to REV with rk_idx=10, so rk_valid rises after edge E.
REQ-017 When AES_INV_KS_DIRECT_LOAD_EN is defined and key_is_last=0, the block SHALL behave exactly as in REQ-004 to REQ-006.
REQ-018 When AES_INV_KS_DIRECT_LOAD_EN is undefined, the key_is_last port SHALL be absent and every start SHALL run FWD.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> rk_valid rises after edge E+10 with rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_idx=10.
  - Next beat of the same run -> rk_data=ac7766f319fadc2128d12941575c006e, rk_idx=9.
  - Final beat of the same run -> rk_data=2b7e151628aed2a6abf7158809cf4f3c with rk_idx=0 and rk_last=1; busy=0 the following cycle.
  - Backpressure: rk_ready held 0 for 5 cycles at rk_idx=7 -> rk_data and rk_idx are unchanged for those cycles, and exactly 11 transfers occur in total.
  - start pulsed during FWD and REV -> no effect, and the sequence is identical to the first scenario; clr at rk_idx=4 -> IDLE next cycle with rk_valid=0.
  - rst asserted mid-FWD (cnt=5) -> all outputs are 0 immediately without a clock edge; with AES_INV_KS_DIRECT_LOAD_EN defined, key_is_last=1 and key_in=d014f9a8... -> rk_valid after edge E and the same 11 keys as the first scenario.
